// File: rtl/pic24_icsp_target_if.sv
// ICSP pin bundle and target-side status/handshake signals for pic24_icsp_target.
// The master modport is the programmer/host side; the slave modport is the target.
interface pic24_icsp_target_if;
    logic        PGCx;
    logic        PGDx_in;
    logic        MCLRn;
    logic        PGDx_out;
    logic        PGDx_dir;
    logic        icsp_mode;
    logic [23:0] instr;
    logic        instr_valid;
    logic        regout_req;
    logic [15:0] regout_data;
    logic        bad_cmd;

    modport master (
        output PGCx, PGDx_in, MCLRn, regout_data,
        input  PGDx_out, PGDx_dir, icsp_mode, instr, instr_valid, regout_req, bad_cmd
    );

    modport slave (
        input  PGCx, PGDx_in, MCLRn, regout_data,
        output PGDx_out, PGDx_dir, icsp_mode, instr, instr_valid, regout_req, bad_cmd
    );
endinterface

// File: rtl/pic24_icsp_target.sv
// PIC24 ICSP target: key-sequence entry, SIX instruction capture, REGOUT readback.
// Host pins are oversampled on clk through 2-flop synchronizers.
module pic24_icsp_target #(
    parameter logic [31:0] ICSP_KEY      = 32'h4D434851,
    parameter int unsigned PRE_CLKS      = 9,
    parameter int unsigned REG_IDLE_CLKS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    pic24_icsp_target_if.slave        bus
);
    typedef enum logic [3:0] {
        ST_OFF, ST_KEY, ST_KEY_OK, ST_PRE, ST_CMD,
        ST_SIX_DATA, ST_REG_IDLE, ST_REG_DATA, ST_SKIP
    } state_t;

    localparam logic [4:0] PRE_LAST  = 5'(PRE_CLKS - 1);
    localparam logic [4:0] IDLE_LAST = 5'(REG_IDLE_CLKS - 1);

    logic [1:0]  pgc_sync_r, pgd_sync_r, mclr_sync_r;
    logic        pgc_prev_r, mclr_prev_r;
    logic        pgc_rise_s, pgc_fall_s, mclr_rise_s, pgd_s, mclr_s, abort_s;

    state_t      state_r, state_nxt;
    logic [31:0] key_r, key_nxt;
    logic [4:0]  cnt_r, cnt_nxt;
    logic [23:0] shift_r, shift_nxt;
    logic [15:0] out_r, out_nxt;
    logic [23:0] instr_r, instr_nxt;
    logic        mode_r, mode_nxt, dir_r, dir_nxt, pgd_out_r, pgd_out_nxt;
    logic        valid_r, valid_nxt, req_r, req_nxt, bad_r, bad_nxt;

    // Synchronize host pins and keep one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pgc_sync_r  <= 2'b00;
            pgd_sync_r  <= 2'b00;
            mclr_sync_r <= 2'b11;
            pgc_prev_r  <= 1'b0;
            mclr_prev_r <= 1'b1;
        end else begin
            pgc_sync_r  <= {pgc_sync_r[0], bus.PGCx};
            pgd_sync_r  <= {pgd_sync_r[0], bus.PGDx_in};
            mclr_sync_r <= {mclr_sync_r[0], bus.MCLRn};
            pgc_prev_r  <= pgc_sync_r[1];
            mclr_prev_r <= mclr_sync_r[1];
        end
    end

    assign pgd_s       = pgd_sync_r[1];
    assign mclr_s      = mclr_sync_r[1];
    assign pgc_rise_s  = pgc_sync_r[1] & ~pgc_prev_r;
    assign pgc_fall_s  = ~pgc_sync_r[1] & pgc_prev_r;
    assign mclr_rise_s = mclr_s & ~mclr_prev_r;
    // MCLRn low while in programming mode wins over any PGC edge in the same cycle.
    assign abort_s     = ~mclr_s & (state_r != ST_OFF) & (state_r != ST_KEY) & (state_r != ST_KEY_OK);

    // Next-state and next-output logic for the ICSP protocol FSM.
    always_comb begin
        state_nxt   = state_r;
        key_nxt     = key_r;
        cnt_nxt     = cnt_r;
        shift_nxt   = shift_r;
        out_nxt     = out_r;
        instr_nxt   = instr_r;
        mode_nxt    = mode_r;
        dir_nxt     = dir_r;
        pgd_out_nxt = pgd_out_r;
        valid_nxt   = 1'b0;
        req_nxt     = 1'b0;
        bad_nxt     = 1'b0;
        if (abort_s) begin
            state_nxt   = ST_KEY;
            key_nxt     = 32'h0000_0000;
            cnt_nxt     = 5'd0;
            shift_nxt   = 24'h00_0000;
            out_nxt     = 16'h0000;
            mode_nxt    = 1'b0;
            dir_nxt     = 1'b1;
            pgd_out_nxt = 1'b0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    if (!mclr_s) begin
                        state_nxt = ST_KEY;
                        key_nxt   = 32'h0000_0000;
                    end else begin
                        state_nxt = ST_OFF;
                    end
                end
                ST_KEY: begin
                    if (key_r == ICSP_KEY) begin
                        state_nxt = ST_KEY_OK;
                    end else if (mclr_s) begin
                        state_nxt = ST_OFF;
                    end else if (pgc_rise_s) begin
                        key_nxt = {key_r[30:0], pgd_s};
                    end else begin
                        state_nxt = ST_KEY;
                    end
                end
                ST_KEY_OK: begin
                    if (mclr_rise_s) begin
                        state_nxt = ST_PRE;
                        mode_nxt  = 1'b1;
                        cnt_nxt   = 5'd0;
                    end else begin
                        state_nxt = ST_KEY_OK;
                    end
                end
                ST_PRE: begin
                    if (pgc_rise_s && (cnt_r == PRE_LAST)) begin
                        state_nxt = ST_SIX_DATA;
                        cnt_nxt   = 5'd0;
                    end else if (pgc_rise_s) begin
                        cnt_nxt = cnt_r + 5'd1;
                    end else begin
                        state_nxt = ST_PRE;
                    end
                end
                ST_CMD: begin
                    if (pgc_rise_s) begin
                        shift_nxt = {shift_r[22:0], pgd_s};
                        cnt_nxt   = cnt_r + 5'd1;
                        if (cnt_r == 5'd3) begin
                            cnt_nxt = 5'd0;
                            case (shift_nxt[3:0])
                                4'b0000: state_nxt = ST_SIX_DATA;
                                4'b0001: begin
                                    state_nxt = ST_REG_IDLE;
                                    req_nxt   = 1'b1;
                                end
                                default: begin
                                    state_nxt = ST_SKIP;
                                    bad_nxt   = 1'b1;
                                end
                            endcase
                        end else begin
                            state_nxt = ST_CMD;
                        end
                    end else begin
                        state_nxt = ST_CMD;
                    end
                end
                ST_SIX_DATA: begin
                    if (pgc_rise_s) begin
                        shift_nxt = {shift_r[22:0], pgd_s};
                        cnt_nxt   = cnt_r + 5'd1;
                        if (cnt_r == 5'd23) begin
                            state_nxt = ST_CMD;
                            cnt_nxt   = 5'd0;
                            instr_nxt = shift_nxt;
                            valid_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_SIX_DATA;
                        end
                    end else begin
                        state_nxt = ST_SIX_DATA;
                    end
                end
                ST_REG_IDLE: begin
                    if (pgc_rise_s && (cnt_r == IDLE_LAST)) begin
                        state_nxt   = ST_REG_DATA;
                        cnt_nxt     = 5'd0;
                        out_nxt     = bus.regout_data;
                        dir_nxt     = 1'b0;
                        pgd_out_nxt = bus.regout_data[15];
                    end else if (pgc_rise_s) begin
                        cnt_nxt = cnt_r + 5'd1;
                    end else begin
                        state_nxt = ST_REG_IDLE;
                    end
                end
                ST_REG_DATA: begin
                    // Bit 15 went out on the last idle rise; rises 1..15 shift out the
                    // rest, rise 16 completes the word and the next fall releases PGD.
                    if (pgc_rise_s && (cnt_r < 5'd16)) begin
                        cnt_nxt = cnt_r + 5'd1;
                        if (cnt_r != 5'd15) begin
                            out_nxt     = {out_r[14:0], 1'b0};
                            pgd_out_nxt = out_r[14];
                        end else begin
                            pgd_out_nxt = pgd_out_r;
                        end
                    end else if (pgc_fall_s && (cnt_r == 5'd16)) begin
                        state_nxt   = ST_CMD;
                        cnt_nxt     = 5'd0;
                        dir_nxt     = 1'b1;
                        pgd_out_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_REG_DATA;
                    end
                end
                ST_SKIP: begin
                    if (pgc_rise_s && (cnt_r == 5'd23)) begin
                        state_nxt = ST_CMD;
                        cnt_nxt   = 5'd0;
                    end else if (pgc_rise_s) begin
                        cnt_nxt = cnt_r + 5'd1;
                    end else begin
                        state_nxt = ST_SKIP;
                    end
                end
                default: begin
                    state_nxt   = ST_OFF;
                    mode_nxt    = 1'b0;
                    dir_nxt     = 1'b1;
                    pgd_out_nxt = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_OFF;
            key_r     <= 32'h0000_0000;
            cnt_r     <= 5'd0;
            shift_r   <= 24'h00_0000;
            out_r     <= 16'h0000;
            instr_r   <= 24'h00_0000;
            mode_r    <= 1'b0;
            dir_r     <= 1'b1;
            pgd_out_r <= 1'b0;
            valid_r   <= 1'b0;
            req_r     <= 1'b0;
            bad_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            key_r     <= key_nxt;
            cnt_r     <= cnt_nxt;
            shift_r   <= shift_nxt;
            out_r     <= out_nxt;
            instr_r   <= instr_nxt;
            mode_r    <= mode_nxt;
            dir_r     <= dir_nxt;
            pgd_out_r <= pgd_out_nxt;
            valid_r   <= valid_nxt;
            req_r     <= req_nxt;
            bad_r     <= bad_nxt;
        end
    end

    assign bus.PGDx_out    = pgd_out_r & ~dir_r;
    assign bus.PGDx_dir    = dir_r;
    assign bus.icsp_mode   = mode_r;
    assign bus.instr       = instr_r;
    assign bus.instr_valid = valid_r;
    assign bus.regout_req  = req_r;
    assign bus.bad_cmd     = bad_r;
endmodule

// File: tb/tb_pic24_icsp_target.sv
// Directed self-checking bench for pic24_icsp_target: entry, SIX, REGOUT,
// bad command skip, MCLRn abort/priority and asynchronous reset.
module tb_pic24_icsp_target;
    localparam logic [31:0] KEY = 32'h4D434851;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n_valid = 0, n_req = 0, n_bad = 0;
    int   v0, r0, b0;
    logic rise_out, rise_dir, fall_out, fall_dir;

    pic24_icsp_target_if bus ();

    pic24_icsp_target dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count clk cycles each pulse output is high; one pulse of one cycle adds exactly 1.
    always @(posedge clk) begin
        if (bus.instr_valid) n_valid <= n_valid + 1;
        if (bus.regout_req)  n_req   <= n_req + 1;
        if (bus.bad_cmd)     n_bad   <= n_bad + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PGC period: 8 clk low (PGD set up early), 6 clk high; samples after each edge.
    task automatic pgc_clock(input logic b);
        bus.PGDx_in = b;
        wait_clk(3);
        bus.PGCx = 1'b1;
        wait_clk(5);
        rise_out = bus.PGDx_out;
        rise_dir = bus.PGDx_dir;
        wait_clk(1);
        bus.PGCx = 1'b0;
        wait_clk(5);
        fall_out = bus.PGDx_out;
        fall_dir = bus.PGDx_dir;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) pgc_clock(v[i]);
    endtask

    task automatic enter_icsp();
        bus.MCLRn = 1'b0;
        wait_clk(4);
        send_bits(KEY, 32);
        wait_clk(4);
        bus.MCLRn = 1'b1;
        wait_clk(4);
        send_bits(32'h0, 9);
    endtask

    task automatic test_reset();
        bus.PGCx = 1'b0; bus.PGDx_in = 1'b0; bus.MCLRn = 1'b1; bus.regout_data = 16'h0000;
        rst = 1'b1;
        wait_clk(3);
        if (bus.icsp_mode !== 1'b0) begin failures++; $display("FAIL rst_mode: got %b want 0", bus.icsp_mode); end
        checks++;
        if (bus.PGDx_dir !== 1'b1) begin failures++; $display("FAIL rst_dir: got %b want 1", bus.PGDx_dir); end
        checks++;
        if ({bus.PGDx_out, bus.instr_valid, bus.regout_req, bus.bad_cmd} !== 4'b0000) begin
            failures++; $display("FAIL rst_outs: got %b want 0000", {bus.PGDx_out, bus.instr_valid, bus.regout_req, bus.bad_cmd});
        end
        checks++;
        if (bus.instr !== 24'h000000) begin failures++; $display("FAIL rst_instr: got %h want 000000", bus.instr); end
        checks++;
        rst = 1'b0;
        wait_clk(4);
        // Key and clocks with MCLRn never low after reset must not enter ICSP mode.
        v0 = n_valid;
        send_bits(KEY, 32);
        send_bits(32'h0, 9);
        send_bits(32'h040200, 24);
        if (bus.icsp_mode !== 1'b0 || n_valid != v0) begin
            failures++; $display("FAIL no_fresh_mclr: mode %b valids %0d want 0 0", bus.icsp_mode, n_valid - v0);
        end
        checks++;
    endtask

    task automatic test_six_entry();
        enter_icsp();
        if (bus.icsp_mode !== 1'b1) begin failures++; $display("FAIL entry_mode: got %b want 1", bus.icsp_mode); end
        checks++;
        v0 = n_valid;
        send_bits(32'h040200, 24);
        if (bus.instr !== 24'h040200) begin failures++; $display("FAIL six_instr: got %h want 040200", bus.instr); end
        checks++;
        if (n_valid - v0 != 1) begin failures++; $display("FAIL six_valid: got %0d want 1", n_valid - v0); end
        checks++;
    endtask

    task automatic test_regout();
        logic [15:0] w;
        w = 16'hA55A;
        bus.regout_data = w;
        r0 = n_req;
        send_bits(32'h1, 4);
        if (n_req - r0 != 1) begin failures++; $display("FAIL regout_req: got %0d want 1", n_req - r0); end
        checks++;
        for (int i = 1; i <= 7; i++) begin
            pgc_clock(1'b0);
            if (rise_dir !== 1'b1) begin failures++; $display("FAIL idle_dir%0d: got %b want 1", i, rise_dir); end
            checks++;
        end
        pgc_clock(1'b0);
        if (rise_dir !== 1'b0 || rise_out !== w[15]) begin
            failures++; $display("FAIL reg_bit15: dir %b out %b want 0 %b", rise_dir, rise_out, w[15]);
        end
        checks++;
        for (int j = 1; j <= 15; j++) begin
            pgc_clock(1'b0);
            if (rise_dir !== 1'b0 || rise_out !== w[15-j]) begin
                failures++; $display("FAIL reg_bit%0d: dir %b out %b want 0 %b", 15 - j, rise_dir, rise_out, w[15-j]);
            end
            checks++;
        end
        pgc_clock(1'b0);
        if (rise_dir !== 1'b0) begin failures++; $display("FAIL reg_hold16: got %b want 0", rise_dir); end
        checks++;
        if (fall_dir !== 1'b1 || fall_out !== 1'b0) begin
            failures++; $display("FAIL reg_release: dir %b out %b want 1 0", fall_dir, fall_out);
        end
        checks++;
        v0 = n_valid;
        send_bits(32'h0, 4);
        send_bits(32'h123456, 24);
        if (bus.instr !== 24'h123456 || n_valid - v0 != 1) begin
            failures++; $display("FAIL six_after_reg: instr %h valids %0d want 123456 1", bus.instr, n_valid - v0);
        end
        checks++;
    endtask

    task automatic test_bad_cmd();
        b0 = n_bad;
        v0 = n_valid;
        send_bits(32'h6, 4);
        if (n_bad - b0 != 1) begin failures++; $display("FAIL bad_cmd: got %0d want 1", n_bad - b0); end
        checks++;
        send_bits(32'hFFFFFF, 24);
        send_bits(32'h0, 4);
        send_bits(32'h000000, 24);
        if (bus.instr !== 24'h000000 || n_valid - v0 != 1 || n_bad - b0 != 1) begin
            failures++; $display("FAIL skip_then_six: instr %h valids %0d bads %0d want 000000 1 1", bus.instr, n_valid - v0, n_bad - b0);
        end
        checks++;
    endtask

    task automatic test_priority();
        r0 = n_req;
        send_bits(32'h0, 3);
        bus.PGDx_in = 1'b1;
        wait_clk(3);
        bus.PGCx = 1'b1;
        bus.MCLRn = 1'b0;
        wait_clk(5);
        if (n_req != r0 || bus.icsp_mode !== 1'b0 || bus.PGDx_dir !== 1'b1) begin
            failures++; $display("FAIL mclr_priority: reqs %0d mode %b dir %b want 0 0 1", n_req - r0, bus.icsp_mode, bus.PGDx_dir);
        end
        checks++;
        bus.PGCx = 1'b0;
        wait_clk(5);
    endtask

    task automatic test_wrong_key();
        v0 = n_valid; r0 = n_req; b0 = n_bad;
        bus.MCLRn = 1'b0;
        wait_clk(4);
        send_bits(32'h4D434850, 32);
        wait_clk(4);
        bus.MCLRn = 1'b1;
        wait_clk(4);
        send_bits(32'h0, 9);
        send_bits(32'h040200, 24);
        if (bus.icsp_mode !== 1'b0 || bus.PGDx_dir !== 1'b1) begin
            failures++; $display("FAIL wrong_key_mode: mode %b dir %b want 0 1", bus.icsp_mode, bus.PGDx_dir);
        end
        checks++;
        if (n_valid != v0 || n_req != r0 || n_bad != b0) begin
            failures++; $display("FAIL wrong_key_pulses: got %0d %0d %0d want 0 0 0", n_valid - v0, n_req - r0, n_bad - b0);
        end
        checks++;
    endtask

    task automatic test_abort_regdata();
        enter_icsp();
        send_bits(32'h000000, 24);
        bus.regout_data = 16'hA55A;
        send_bits(32'h1, 4);
        send_bits(32'h0, 8);
        send_bits(32'h0, 7);
        if (rise_dir !== 1'b0) begin failures++; $display("FAIL pre_abort_dir: got %b want 0", rise_dir); end
        checks++;
        bus.MCLRn = 1'b0;
        wait_clk(3);
        if (bus.PGDx_dir !== 1'b1 || bus.icsp_mode !== 1'b0 || bus.PGDx_out !== 1'b0) begin
            failures++; $display("FAIL abort_regdata: dir %b mode %b out %b want 1 0 0", bus.PGDx_dir, bus.icsp_mode, bus.PGDx_out);
        end
        checks++;
        // Abort lands in KEY: the key can follow immediately with MCLRn still low.
        enter_icsp();
        v0 = n_valid;
        send_bits(32'hABCDEF, 24);
        if (bus.instr !== 24'hABCDEF || bus.icsp_mode !== 1'b1 || n_valid - v0 != 1) begin
            failures++; $display("FAIL reentry_six: instr %h mode %b valids %0d want abcdef 1 1", bus.instr, bus.icsp_mode, n_valid - v0);
        end
        checks++;
    endtask

    task automatic test_rst_mid_six();
        send_bits(32'h0, 4);
        send_bits(32'h5A5, 12);
        rst = 1'b1;
        #1;
        if (bus.icsp_mode !== 1'b0 || bus.PGDx_dir !== 1'b1 || bus.PGDx_out !== 1'b0 || bus.instr !== 24'h000000) begin
            failures++; $display("FAIL rst_async: mode %b dir %b out %b instr %h want 0 1 0 000000", bus.icsp_mode, bus.PGDx_dir, bus.PGDx_out, bus.instr);
        end
        checks++;
        wait_clk(3);
        rst = 1'b0;
        v0 = n_valid;
        send_bits(32'hA5A, 12);
        send_bits(32'h0, 24);
        if (n_valid != v0 || bus.instr !== 24'h000000 || bus.icsp_mode !== 1'b0) begin
            failures++; $display("FAIL rst_no_resume: valids %0d instr %h mode %b want 0 000000 0", n_valid - v0, bus.instr, bus.icsp_mode);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_six_entry();
        test_regout();
        test_bad_cmd();
        test_priority();
        test_wrong_key();
        test_abort_regdata();
        test_rst_mid_six();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
